rr_arbiter_8: RTL and testbench
===============================

# rr_arbiter_8

Eight-requester round-robin arbiter that shares one downstream resource (bus, encoder or datapath slot) among up to eight clients. It issues a registered one-hot grant plus its encoded 3-bit index, holds the grant until the owner releases it, and rotates priority so every active requester is served within eight grant epochs. It sits between the client request lines and the shared resource's select/enable inputs.

## Interface
- MAX_HOLD, 16, maximum grant duration in cycles before forced revoke (used only when ARB_TIMEOUT_EN is defined; legal range 2..255)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  8  per-client request; bit k = client k wants the resource
- rel  input  1  release strobe from the current grantee; meaningful only while gnt_vld=1
- gnt  output  8  registered one-hot grant; all-zero when idle
- gnt_id  output  3  binary index of the granted client; 3'd0 when idle
- gnt_vld  output  1  high whenever gnt is non-zero
- tmo  output  1  one-cycle pulse on forced revoke (tied 0 when ARB_TIMEOUT_EN is undefined)

## Operation
- Two states: IDLE (no grant) and BUSY (one client owns the resource).
- Rotating pointer ptr[2:0]. Search order is ptr, ptr+1, …, ptr+7 (mod 8); the first set req bit wins.
- IDLE: if req != 0, the winner k is registered. Next state is BUSY with gnt=1<<k, gnt_id=k, gnt_vld=1, and ptr <= k+1 (mod 8). If req == 0, the block stays in IDLE.
- BUSY, end-of-ownership event: rel=1, or req[gnt_id]=0 (the owner dropped its request), or timeout.
  - On the event, the block arbitrates again in the same cycle using the already-advanced ptr. The previous owner is therefore lowest priority.
  - If any req bit is set (the previous owner's bit included), the new grant appears the next cycle with no idle gap. Otherwise the block returns to IDLE with outputs zero.
- BUSY with no event: gnt, gnt_id and ptr hold. req changes on other bits are ignored.
- rel in IDLE is ignored.
- gnt is always one-hot or zero; gnt_id always equals the encoded gnt.
- All outputs are registered; there is no combinational path from req or rel to the outputs.

## Timing
- Reset (asynchronous assert, synchronous deassert at the source): state=IDLE, ptr=0, gnt=8'h00, gnt_id=3'd0, gnt_vld=0, tmo=0, hold counter=0.
  - Asserting rst_n mid-grant drops gnt immediately, without waiting for a clock edge.
- Latency req→gnt: 1 cycle from IDLE. If req is sampled high at edge T, gnt is high after edge T.
- Handover: rel sampled at edge T moves the grant to the next owner after edge T. The old and new grants never overlap and are never both low while a request is pending.
- Minimum ownership is 1 cycle: rel may be asserted in the first grant cycle.
- Simultaneous rel and a new req from the releasing owner: that owner re-wins only if no other req bit is set.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on every new grant and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD-1 with no rel, the grant is revoked as if rel=1, and tmo pulses high for the one cycle following that edge.
  - rel and timeout in the same cycle count as a normal release, with tmo=0.
- ARB_TIMEOUT_EN undefined: no counter, and a grant is held indefinitely until rel or the owner drops req. tmo is constant 0.

## Test plan
- Reset then req=8'h01: gnt=8'h01, gnt_id=0 one cycle later. Then rel=1 with req=8'h00: the block returns to IDLE with gnt=0 and gnt_vld=0.
- req=8'hFF held, rel pulsed every 3 cycles: grants in order 0,1,2,…,7,0. No gap between grants, and each grant lasts exactly 3 cycles.
- Grant to client 5 with req=8'h24, then rel: the next grant is client 2 after one cycle (wrap past 7 to 0 to 2), and ptr becomes 3.
- Owner 3 deasserts req[3] without rel while req[6]=1: gnt moves to 8'h40 after one cycle.
- rst_n asserted low while gnt=8'h10: gnt=0 and gnt_id=0 before the next clock edge. After release, req=8'h10 is granted with ptr restarting at 0.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h03, no rel:
  - Client 0 holds for 4 cycles, then tmo=1 for one cycle and gnt=8'h02.
  - Without the macro, gnt stays 8'h01 for 100 cycles and tmo stays 0.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-requester round-robin arbiter with a registered one-hot grant.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      per-client request, bit k = client k wants the resource
//   rel      release strobe from the current grantee (ignored while idle)
//   gnt      one-hot grant, all-zero when idle
//   gnt_id   binary index of the granted client, 0 when idle
//   gnt_vld  high whenever gnt is non-zero
//   tmo      one-cycle pulse after a forced revoke
//
// Optional feature: define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles.
// Without it, MAX_HOLD is only range-checked and tmo is constant 0.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_vld,
    output logic       tmo
);

    localparam int unsigned NumReq = 8;
    localparam int unsigned IdW    = 3;
    localparam int unsigned CntW   = 8;

    // Reject hold limits the 8-bit counter cannot represent.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter_8: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [IdW-1:0]      ptr_q, ptr_d;
    logic [NumReq-1:0]   gnt_q, gnt_d;
    logic [IdW-1:0]      gnt_id_q, gnt_id_d;
    logic                gnt_vld_q, gnt_vld_d;
    logic                tmo_q, tmo_d;
    logic                tmo_hit;

`ifdef ARB_TIMEOUT_EN
    logic [CntW-1:0]     cnt_q, cnt_d;

    // Owner has used its full allowance once the counter reaches MAX_HOLD-1.
    assign tmo_hit = (state_q == BUSY) && (cnt_q == CntW'(MAX_HOLD - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Round-robin search from ptr_q; the lowest offset with a set request wins.
    logic              win_vld;
    logic [IdW-1:0]    win_id;
    logic [IdW-1:0]    cand;

    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            cand = ptr_q + IdW'(i);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    // Ownership ends on release, owner dropping its request, or timeout.
    logic end_evt;
    assign end_evt = (state_q == BUSY) && (rel || !req[gnt_id_q] || tmo_hit);

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_vld_d = gnt_vld_q;
        tmo_d     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        if (state_q == IDLE || end_evt) begin
            if (win_vld) begin
                state_d   = BUSY;
                ptr_d     = win_id + IdW'(1);
                gnt_d     = NumReq'(1) << win_id;
                gnt_id_d  = win_id;
                gnt_vld_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end else begin
                state_d   = IDLE;
                gnt_d     = '0;
                gnt_id_d  = '0;
                gnt_vld_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            // A release coinciding with the timeout is an ordinary release.
            tmo_d = tmo_hit && !rel && req[gnt_id_q];
        end else begin
`ifdef ARB_TIMEOUT_EN
            cnt_d = cnt_q + CntW'(1);
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            gnt_vld_q <= 1'b0;
            tmo_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            gnt_vld_q <= gnt_vld_d;
            tmo_q     <= tmo_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_vld = gnt_vld_q;
    assign tmo     = tmo_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed stimulus for rr_arbiter_8 with a per-cycle reference model.
module tb_rr_arbiter_8;

`ifdef ARB_TIMEOUT_EN
    localparam int MH     = 4;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int MH     = 16;
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       rel = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       tmo;

    int checks = 0;
    int errors = 0;

    rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .tmo     (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: who owns the resource, where the search starts, how long it has held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_tmo   = 1'b0;

    task automatic model_pick();
        int w;
        w = -1;
        for (int i = 0; i < 8; i++) begin
            if (w < 0 && req[(m_ptr + i) % 8]) w = (m_ptr + i) % 8;
        end
        if (w >= 0) begin
            m_owner = w;
            m_ptr   = (w + 1) % 8;
            m_held  = 1;
        end else begin
            m_owner = -1;
            m_held  = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_tmo   = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (m_owner < 0) begin
                model_pick();
            end else begin
                bit expired;
                expired = TMO_EN && (m_held == MH);
                if (rel || !req[m_owner] || expired) begin
                    m_tmo = expired && !rel && req[m_owner];
                    model_pick();
                end else begin
                    m_held++;
                end
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        logic [7:0] eg;
        eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        check("cmp_gnt", 32'(gnt), 32'(eg));
        check("cmp_gnt_id", 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("cmp_gnt_vld", 32'(gnt_vld), 32'(m_owner >= 0));
        check("cmp_tmo", 32'(tmo), 32'(m_tmo));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        rel   = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state.
        cyc(2);
        check("rst_gnt", 32'(gnt), 32'h00);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        check("rst_gnt_vld", 32'(gnt_vld), 32'd0);
        check("rst_tmo", 32'(tmo), 32'd0);
        rst_n = 1'b1;

        // Single request, then release back to idle.
        req = 8'h01;
        cyc(1);
        check("t1_gnt", 32'(gnt), 32'h01);
        check("t1_id", 32'(gnt_id), 32'd0);
        req = 8'h00;
        rel = 1'b1;
        cyc(1);
        rel = 1'b0;
        check("t1_idle_gnt", 32'(gnt), 32'h00);
        check("t1_idle_vld", 32'(gnt_vld), 32'd0);

        // Release while idle changes nothing.
        rel = 1'b1;
        cyc(1);
        rel = 1'b0;
        check("idle_rel", 32'(gnt), 32'h00);

        // All requesting, release every third cycle: 0..7 then 0, no gaps.
        do_reset();
        req = 8'hFF;
        cyc(1);
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < 3; c++) begin
                logic [7:0] e;
                e = 8'h01 << (g % 8);
                check("rot_gnt", 32'(gnt), 32'(e));
                rel = (c == 2);
                cyc(1);
            end
        end
        rel = 1'b0;
        req = 8'h00;
        cyc(1);

        // Client 5 releases with req=24: wrap to client 2, pointer to 3.
        do_reset();
        req = 8'h20;
        cyc(1);
        check("w_gnt5", 32'(gnt), 32'h20);
        req = 8'h24;
        rel = 1'b1;
        cyc(1);
        rel = 1'b0;
        check("w_gnt2", 32'(gnt), 32'h04);
        check("w_id2", 32'(gnt_id), 32'd2);
        check("w_ptr3", 32'(m_ptr), 32'd3);
        req = 8'h00;
        cyc(1);

        // Owner 3 drops its request while client 6 waits.
        req = 8'h08;
        cyc(1);
        check("d_gnt3", 32'(gnt), 32'h08);
        req = 8'h48;
        cyc(1);
        check("d_hold3", 32'(gnt), 32'h08);
        req = 8'h40;
        cyc(1);
        check("d_gnt6", 32'(gnt), 32'h40);
        check("d_id6", 32'(gnt_id), 32'd6);
        req = 8'h00;
        cyc(1);

        // Asynchronous reset while client 4 owns the grant.
        req = 8'h10;
        cyc(1);
        check("r_gnt4", 32'(gnt), 32'h10);
        #2 rst_n = 1'b0;
        #1;
        check("r_async_gnt", 32'(gnt), 32'h00);
        check("r_async_id", 32'(gnt_id), 32'd0);
        check("r_async_vld", 32'(gnt_vld), 32'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        check("r_regnt4", 32'(gnt), 32'h10);
        check("r_ptr5", 32'(m_ptr), 32'd5);
        // From pointer 5 the search wraps to client 0 before reaching client 4.
        req = 8'h11;
        rel = 1'b1;
        cyc(1);
        rel = 1'b0;
        check("r_wrap0", 32'(gnt), 32'h01);
        req = 8'h00;
        cyc(1);

        // Releasing owner re-wins only when alone.
        req = 8'h01;
        cyc(1);
        req = 8'h01;
        rel = 1'b1;
        cyc(1);
        check("s_rewin", 32'(gnt), 32'h01);
        req = 8'h03;
        cyc(1);
        rel = 1'b0;
        check("s_move1", 32'(gnt), 32'h02);
        req = 8'h00;
        cyc(1);

        // Long hold with req=03 and no release.
        do_reset();
        req = 8'h03;
        cyc(1);
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            check("to_hold0", 32'(gnt), 32'h01);
            check("to_notmo", 32'(tmo), 32'd0);
            cyc(1);
        end
        check("to_gnt1", 32'(gnt), 32'h02);
        check("to_tmo", 32'(tmo), 32'd1);
        cyc(1);
        check("to_tmo_off", 32'(tmo), 32'd0);
`else
        for (int c = 0; c < 100; c++) begin
            check("hold_gnt0", 32'(gnt), 32'h01);
            check("hold_tmo0", 32'(tmo), 32'd0);
            cyc(1);
        end
`endif
        req = 8'h00;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
